// File: rtl/controller_pkg.sv
// Shared CPU definitions: instruction opcodes (also used by the ALU) and the
// eight-step instruction phase sequence driven by the controller.
package controller_pkg;

  localparam int OPCODE_W = 3;
  localparam int PHASE_W  = 3;

  typedef enum logic [OPCODE_W-1:0] {
    HLT = 3'b000,
    SKZ = 3'b001,
    ADD = 3'b010,
    AND = 3'b011,
    XOR = 3'b100,
    LDA = 3'b101,
    STO = 3'b110,
    JMP = 3'b111
  } opcode_t;

  typedef enum logic [PHASE_W-1:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_t;

  // Opcodes whose result is written back into the accumulator; these read
  // their operand from memory.
  function automatic logic is_aluop(input opcode_t op);
    return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
  endfunction

endpackage

// File: rtl/controller.sv
// CPU sequencing controller.
// Steps through an 8-phase instruction cycle and decodes the control strobes
// for the current phase from the instruction opcode and the accumulator zero
// flag. A HLT instruction freezes the sequence in OP_ADDR until reset.
//
// Ports:
//   clk     in   clock, all state changes on rising edge
//   rst     in   synchronous active-high reset
//   opcode  in   [2:0] opcode from the instruction register
//   zero    in   accumulator-is-zero flag from the ALU
//   sel     out  address mux select (1 = program counter, 0 = IR operand)
//   rd      out  memory read enable
//   ld_ir   out  instruction register load
//   halt    out  CPU halted indication
//   inc_pc  out  program counter increment
//   ld_ac   out  accumulator load from ALU output
//   ld_pc   out  program counter load from IR operand
//   wr      out  memory write enable
//   data_e  out  accumulator drive onto data bus
module controller
  import controller_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  output logic                sel,
  output logic                rd,
  output logic                ld_ir,
  output logic                halt,
  output logic                inc_pc,
  output logic                ld_ac,
  output logic                ld_pc,
  output logic                wr,
  output logic                data_e
);

  phase_t  phase_reg, phase_next;
  logic    halted_reg, halted_next;
  opcode_t op;
  logic    aluop;

  assign op    = opcode_t'(opcode);
  assign aluop = is_aluop(op);

  // State register: reset overrides both advance and halt.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_reg  <= INST_ADDR;
      halted_reg <= 1'b0;
    end else begin
      phase_reg  <= phase_next;
      halted_reg <= halted_next;
    end
  end

  // Next-state: advance one phase per clock unless halted. HLT seen in
  // OP_ADDR latches the sticky halted flag and holds the phase there.
  always_comb begin
    phase_next  = phase_t'(phase_reg + 3'd1);
    halted_next = halted_reg;
    if (halted_reg) begin
      phase_next = phase_reg;
    end else if (phase_reg == OP_ADDR && op == HLT) begin
      phase_next  = phase_reg;
      halted_next = 1'b1;
    end
  end

  // Output decode. While reset is asserted the outputs already show the
  // INST_ADDR decode, so nothing mid-instruction leaks out during reset.
  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    halt   = 1'b0;
    inc_pc = 1'b0;
    ld_ac  = 1'b0;
    ld_pc  = 1'b0;
    wr     = 1'b0;
    data_e = 1'b0;
    if (rst) begin
      sel = 1'b1;
    end else if (halted_reg) begin
      halt = 1'b1;
    end else begin
      case (phase_reg)
        INST_ADDR: begin
          sel = 1'b1;
        end
        INST_FETCH: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        INST_LOAD, IDLE: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        OP_ADDR: begin
          inc_pc = 1'b1;
          halt   = (op == HLT);
        end
        OP_FETCH: begin
          rd = aluop;
        end
        ALU_OP: begin
          rd     = aluop;
          // Skip: the extra increment here steps over the next instruction.
          inc_pc = (op == SKZ) && zero;
          ld_pc  = (op == JMP);
          data_e = (op == STO);
        end
        STORE: begin
          rd     = aluop;
          ld_ac  = aluop;
          inc_pc = (op == JMP);
          ld_pc  = (op == JMP);
          wr     = (op == STO);
          data_e = (op == STO);
        end
        default: begin
          sel = 1'b0;
        end
      endcase
    end
  end

endmodule
